// File: rtl/mux_scan_pkg.sv
// ============================================================================
// mux_scan_pkg : state encoding and default parameters shared by mux_scan
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NUM_CH = 16;
  localparam int DEF_DWELL  = 4;

endpackage

`default_nettype wire

// File: rtl/mux_nx1.sv
// ============================================================================
// mux_nx1 : combinational N-to-1 selector over a flat channel bus
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_nx1 #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 16,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH*WIDTH-1:0] x,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        y
);

  logic [WIDTH-1:0] ch_arr [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_arr[i] = x[i*WIDTH +: WIDTH];
  end

  assign y = ch_arr[sel];

endmodule

`default_nettype wire

// File: rtl/mux_scan.sv
// ============================================================================
// mux_scan : manual/scanning channel multiplexer with registered output.
//            Define MUX_SCAN_MASK_EN to add the ch_mask scan-enable port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DWELL  = DEF_DWELL,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] x,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    mode,
  input  logic                    start,
  input  logic                    stop,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NUM_CH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]        y,
  output logic                    y_valid,
  output logic [SEL_W-1:0]        y_ch,
  output logic                    busy
);

  localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0] y_ch_q, y_ch_d;
  logic             y_valid_q, y_valid_d;

  logic [SEL_W-1:0] mux_sel;
  logic [WIDTH-1:0] mux_y;
  logic             mask_any;
  logic [SEL_W-1:0] first_ch;
  logic [SEL_W-1:0] next_ch;

`ifdef MUX_SCAN_MASK_EN
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // Descending offsets so the nearest set bit above cur wins; cur itself is the fallback.
  function automatic logic [SEL_W-1:0] next_set(input logic [NUM_CH-1:0] m,
                                                input logic [SEL_W-1:0]  cur);
    logic [SEL_W-1:0] r;
    logic [SEL_W-1:0] idx;
    r = cur;
    for (int i = NUM_CH - 1; i >= 1; i--) begin
      idx = cur + SEL_W'(i);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  assign mask_any = |ch_mask;
  assign first_ch = lowest_set(ch_mask);
  assign next_ch  = next_set(ch_mask, ch_q);
`else
  assign mask_any = 1'b1;
  assign first_ch = '0;
  assign next_ch  = ch_q + SEL_W'(1);
`endif

  assign mux_sel = (state_q == MAN) ? sel_in : ch_q;

  mux_nx1 #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH)
  ) u_mux (
    .x   (x),
    .sel (mux_sel),
    .y   (mux_y)
  );

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!mode) begin
              state_d = MAN;
            end else if (mask_any) begin
              state_d = SCAN;
              ch_d    = first_ch;
              cnt_d   = '0;
            end
          end
        end
        MAN: begin
          y_d       = mux_y;
          y_ch_d    = sel_in;
          y_valid_d = 1'b1;
        end
        SCAN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            // An empty mask at the dwell boundary abandons the scan without a sample.
            if (!mask_any) begin
              state_d = IDLE;
            end else begin
              y_d       = mux_y;
              y_ch_d    = ch_q;
              y_valid_d = 1'b1;
              ch_d      = next_ch;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_ch    = y_ch_q;
  assign busy    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mux_scan.sv
// ============================================================================
// tb_mux_scan : checks two mux_scan instances (DWELL=4 and DWELL=1) against
//               a cycle-count reference model. Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mux_scan;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [NUM_CH*WIDTH-1:0] x;
  logic [SEL_W-1:0]        sel_in;
  logic                    mode;
  logic                    start;
  logic                    stop;
  logic [NUM_CH-1:0]       ch_mask;
  logic [WIDTH-1:0]        y       [2];
  logic                    y_valid [2];
  logic [SEL_W-1:0]        y_ch    [2];
  logic                    busy    [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_scan #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DWELL(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .x(x), .sel_in(sel_in), .mode(mode),
    .start(start), .stop(stop),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask(ch_mask),
`endif
    .y(y[0]), .y_valid(y_valid[0]), .y_ch(y_ch[0]), .busy(busy[0])
  );

  mux_scan #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .x(x), .sel_in(sel_in), .mode(mode),
    .start(start), .stop(stop),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask(ch_mask),
`endif
    .y(y[1]), .y_valid(y_valid[1]), .y_ch(y_ch[1]), .busy(busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dwell_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int low_ch(input logic [NUM_CH-1:0] m);
    for (int k = 0; k < NUM_CH; k++) if (m[k]) return k;
    return 0;
  endfunction

  function automatic int nxt_ch(input logic [NUM_CH-1:0] m, input int cur);
    for (int k = 1; k <= NUM_CH; k++) if (m[(cur + k) % NUM_CH]) return (cur + k) % NUM_CH;
    return cur;
  endfunction

  // Model: 0 idle, 1 manual, 2 scan; samples fall on every multiple of the
  // dwell counted in cycles since scan entry.
  int         m_st [2] = '{0, 0};
  int         m_t  [2] = '{0, 0};
  int         m_ch [2] = '{0, 0};
  int         m_yc [2] = '{0, 0};
  logic [7:0] m_y  [2] = '{8'h00, 8'h00};
  bit         m_v  [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_st[i] = 0; m_t[i] = 0; m_ch[i] = 0; m_yc[i] = 0; m_y[i] = 8'h00; m_v[i] = 1'b0;
      end else begin
        m_v[i] = 1'b0;
        if (stop) begin
          m_st[i] = 0;
        end else if (m_st[i] == 0) begin
          if (start) begin
            if (!mode) m_st[i] = 1;
            else if (ch_mask != '0) begin
              m_st[i] = 2; m_t[i] = 0; m_ch[i] = low_ch(ch_mask);
            end
          end
        end else if (m_st[i] == 1) begin
          m_y[i]  = x[int'(sel_in)*WIDTH +: WIDTH];
          m_yc[i] = int'(sel_in);
          m_v[i]  = 1'b1;
        end else begin
          m_t[i]++;
          if (m_t[i] % dwell_of(i) == 0) begin
            if (ch_mask == '0) m_st[i] = 0;
            else begin
              m_y[i]  = x[m_ch[i]*WIDTH +: WIDTH];
              m_yc[i] = m_ch[i];
              m_v[i]  = 1'b1;
              m_ch[i] = nxt_ch(ch_mask, m_ch[i]);
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d y", i),       32'(y[i]),       32'(m_y[i]));
      chk($sformatf("dut%0d y_ch", i),    32'(y_ch[i]),    32'(m_yc[i]));
      chk($sformatf("dut%0d y_valid", i), 32'(y_valid[i]), 32'(m_v[i]));
      chk($sformatf("dut%0d busy", i),    32'(busy[i]),    32'(m_st[i] != 0));
    end
  end

  task automatic set_ramp();
    for (int i = 0; i < NUM_CH; i++) x[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
  endtask

  initial begin
    logic [SEL_W-1:0] mask_order [4];
    mask_order = '{4'd0, 4'd4, 4'd15, 4'd0};
    set_ramp();
    sel_in = '0; mode = 1'b0; start = 1'b0; stop = 1'b0; ch_mask = '1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset y", 32'(y[0]), 32'h0);
    chk("reset busy", 32'(busy[0]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Manual mode
    start = 1'b1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0; sel_in = 4'd5;
    @(negedge clk);
    chk("man y sel5", 32'(y[0]), 32'h15);
    chk("man ych sel5", 32'(y_ch[0]), 32'd5);
    chk("man valid", 32'(y_valid[0]), 32'd1);
    sel_in = 4'd15;
    @(negedge clk);
    chk("man y sel15", 32'(y[0]), 32'h1F);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("man stop busy", 32'(busy[0]), 32'd0);
    chk("man stop hold", 32'(y[0]), 32'h1F);

    // Scan with wrap
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 17; k++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("scan valid %0d", k), 32'(y_valid[0]), 32'd1);
      chk($sformatf("scan y %0d", k), 32'(y[0]), 32'(8'h10 + (k % NUM_CH)));
      if (k == 0) chk("dwell1 y", 32'(y[1]), 32'h13);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // Stop two cycles after the third sample
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("third sample", 32'(y[0]), 32'h12);
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop busy", 32'(busy[0]), 32'd0);
    chk("stop valid", 32'(y_valid[0]), 32'd0);
    repeat (5) @(negedge clk);
    chk("stop hold y", 32'(y[0]), 32'h12);

    // start and stop together
    start = 1'b1; stop = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start+stop busy", 32'(busy[0]), 32'd0);
    repeat (4) @(negedge clk);

    // Asynchronous reset at cnt=2
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst y", 32'(y[0]), 32'h0);
    chk("async rst valid", 32'(y_valid[0]), 32'd0);
    chk("async rst busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("restart y", 32'(y[0]), 32'h10);
    chk("restart valid", 32'(y_valid[0]), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

`ifdef MUX_SCAN_MASK_EN
    ch_mask = 16'h8011;
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("mask ch %0d", k), 32'(y_ch[0]), 32'(mask_order[k]));
    end
    ch_mask = '0;
    repeat (4) @(negedge clk);
    chk("empty mask busy", 32'(busy[0]), 32'd0);
    chk("empty mask valid", 32'(y_valid[0]), 32'd0);
    ch_mask = '1;
`else
    chk("order table", 32'(mask_order[2]), 32'd15);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) x[i*WIDTH +: WIDTH] = 8'($urandom);
      sel_in = SEL_W'($urandom);
      mode   = 1'($urandom);
      start  = ($urandom_range(0, 9) == 0);
      stop   = ($urandom_range(0, 59) == 0);
`ifdef MUX_SCAN_MASK_EN
      if ($urandom_range(0, 40) == 0)
        ch_mask = ($urandom_range(0, 5) == 0) ? '0 : NUM_CH'($urandom);
`endif
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
